shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel shifter for the processor datapath. It supersedes the single-cycle 32-bit shifter:
- width and pipeline depth are generic;
- rotate-right (ROR) is added;
- a carry-out and a zero flag are produced;
- operands move through a valid/ready handshake with backpressure and flush.

It sits between the operand-select stage and the ALU result mux. Multi-cycle shifts can be used here without stretching the critical path.

## Interface
Parameters:
- WIDTH, 32, data width; power of two, 8..64
- STAGES, 2, number of register stages; 1..log2(WIDTH)

Ports:
- CLK  in  1  clock, rising-edge
- RESETn  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous; drops every in-flight operation
- InValid  in  1  operation presented
- InReady  out  1  pipeline can accept this cycle
- Sh  in  2  mode: LSL=00, LSR=01, ASR=10, ROR=11
- Shamt  in  log2(WIDTH)  shift amount
- ShIn  in  WIDTH  operand
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- ShOut  out  WIDTH  result
- Carry  out  1  last bit shifted out
- Zero  out  1  ShOut == 0

One clock. Reset is asynchronous and active-low.

## Operation
Shift modes:
- LSL: fill with zeros from the LSB.
- LSR: fill with zeros from the MSB.
- ASR: fill with ShIn[WIDTH-1].
- ROR: rotate right by Shamt.

Shamt is taken modulo WIDTH by construction, so no over-range amount exists.

Carry:
- LSL: ShIn[WIDTH-Shamt]
- LSR and ASR: ShIn[Shamt-1]
- ROR: ShOut[WIDTH-1]
- Shamt==0: Carry=0 in every mode.

Zero is computed from the final ShOut in the last stage.

Pipeline structure:
- The shifter is log2(WIDTH) mux levels; level i shifts by 2^i.
- Level i belongs to stage floor(i*STAGES/log2(WIDTH)).
- Each stage ends in a register holding valid, data, Sh, the remaining Shamt bits and the precomputed carry.
- Carry is computed in stage 0 from ShIn and carried along unchanged.

Handshake rules:
- An input transfer occurs when InValid&&InReady. An output transfer occurs when OutValid&&OutReady.
- Stage k advances when its own valid is clear or stage k+1 advances. The last stage advances when OutReady is high or its valid is clear.
- InReady = stage-0 may advance. It is combinational from OutReady through the ready chain and must not depend on InValid.
- While OutValid is high and OutReady is low, ShOut, Carry and Zero hold stable.
- Full-throughput: one result per cycle when OutReady is held high.

Flush:
- Clears all stage valids on the next edge.
- Flush has priority over a simultaneous input transfer; the offered operation is dropped.
- InReady stays at its normal value during Flush.

Reset:
- All valid bits become 0, so OutValid=0.
- ShOut=0, Carry=0, Zero=0 (data registers are reset too).
- Reset asserted mid-operation discards all in-flight operations. The first post-reset result appears only from a new input transfer.

## Timing
- Latency: STAGES cycles from input transfer to OutValid, with OutReady high throughout.
- Throughput: 1 operation per cycle.
- A bubble costs nothing. An empty stage accepts even when downstream is stalled.
- No combinational path from InValid or ShIn to OutValid or ShOut.

## Structure
- Shared package shifter_pkg:
  - the Sh encodings (LSL, LSR, ASR, ROR), which replace the loose `define macros;
  - the function clog2_w used to size Shamt.
- Sub-module shift_stage:
  - parameters WIDTH, FIRST_LVL, NUM_LVL;
  - holds the combinational mux levels and the stage register with the valid/ready logic;
  - shift_pipe instantiates STAGES copies in a generate loop.

## Test plan
1. Mode check, WIDTH=32, STAGES=2, with ShIn=0x8000_00F1 and Shamt=4. Each result appears exactly 2 cycles after its input transfer:
   - LSL -> 0x0000_0F10, Carry=0.
   - LSR -> 0x0800_000F, Carry=0.
   - ASR -> 0xF800_000F, Carry=0.
   - ROR -> 0x1800_000F, Carry=0.
2. Boundaries:
   - Shamt=0, ROR, ShIn=0x1234_5678 -> 0x1234_5678, Carry=0.
   - LSL, Shamt=31, ShIn=0x3 -> 0x8000_0000, Carry=1.
   - LSR, Shamt=1, ShIn=0x1 -> 0, Carry=1, Zero=1.
3. Backpressure: stream 8 ops back-to-back and hold OutReady low for 5 cycles starting at cycle 3. Required: no loss or duplication, results in order, ShOut stable while stalled, InReady low once both stages are full.
4. Flush: assert Flush with 2 ops in flight plus InValid high on the same edge. Next cycle OutValid=0; a new op issued afterwards emerges after exactly STAGES cycles.
5. Reset mid-stream: drop RESETn asynchronously between clock edges with the pipe full. Outputs are immediately OutValid=0 and ShOut=0; the pipe is clean after release.
6. Parameter sweep: WIDTH in {8, 32, 64} crossed with STAGES in {1, log2(WIDTH)}. Run random Sh/Shamt/ShIn against a reference model and check latency = STAGES.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings
// and the elaboration-time helpers that size Shamt and split mux levels into stages.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_e;

    function automatic int clog2_w(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Mux level i lives in stage floor(i*stages/lvls), so a stage's first level is ceil(stage*lvls/stages).
    function automatic int stage_first_lvl(input int stage, input int lvls, input int stages);
        return (stage * lvls + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: a run of mux levels followed by
// the stage register, with the valid/ready slot logic.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      ready_i,
    input  sh_e                       sh_i,
    input  logic [clog2_w(WIDTH)-1:0] shamt_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic                      carry_i,
    input  logic                      zero_i,
    output logic                      valid_o,
    output sh_e                       sh_o,
    output logic [clog2_w(WIDTH)-1:0] shamt_o,
    output logic [WIDTH-1:0]          data_o,
    output logic                      carry_o,
    output logic                      zero_o
);

    localparam int LW       = clog2_w(WIDTH);
    localparam bit IS_FIRST = (FIRST_LVL == 0);
    localparam bit IS_LAST  = ((FIRST_LVL + NUM_LVL) == LW);

    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d, input sh_e sh, input int amt);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        dbl = {d, d} >> amt;
        case (sh)
            SH_LSL:  res = d << amt;
            SH_LSR:  res = d >> amt;
            SH_ASR:  res = $signed(d) >>> amt;
            SH_ROR:  res = dbl[WIDTH-1:0];
            default: res = d;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] lvl_s [0:NUM_LVL];
    logic [LW-1:0]    lsl_idx_s;
    logic [LW-1:0]    rsh_idx_s;
    logic             carry_calc_s;
    logic             advance_s;
    logic [WIDTH-1:0] data_d;
    logic             carry_d;
    logic             zero_d;
    logic             unused_ok;

    logic             valid_q;
    sh_e              sh_q;
    logic [LW-1:0]    shamt_q;
    logic [WIDTH-1:0] data_q;
    logic             carry_q;
    logic             zero_q;

    assign lvl_s[0] = data_i;

    for (genvar j = 0; j < NUM_LVL; j++) begin : g_lvl
        localparam int AMT = 32'sd1 << (FIRST_LVL + j);
        assign lvl_s[j+1] = shamt_i[FIRST_LVL + j] ? shift_lvl(lvl_s[j], sh_i, AMT) : lvl_s[j];
    end

    // WIDTH-Shamt wraps to -Shamt in LW bits, which is exact for every non-zero Shamt.
    assign lsl_idx_s = {LW{1'b0}} - shamt_i;
    assign rsh_idx_s = shamt_i - LW'(1'b1);

    // Carry is the last bit pushed out; ROR's ShOut[WIDTH-1] is the same bit as ShIn[Shamt-1].
    always_comb begin
        carry_calc_s = 1'b0;
        if (shamt_i == {LW{1'b0}}) begin
            carry_calc_s = 1'b0;
        end else begin
            case (sh_i)
                SH_LSL:  carry_calc_s = data_i[lsl_idx_s];
                default: carry_calc_s = data_i[rsh_idx_s];
            endcase
        end
    end

    assign data_d    = lvl_s[NUM_LVL];
    assign carry_d   = IS_FIRST ? carry_calc_s : carry_i;
    assign zero_d    = IS_LAST ? (data_d == {WIDTH{1'b0}}) : zero_i;
    assign advance_s = !valid_q || ready_i;
    assign ready_o   = advance_s;
    assign unused_ok = ^{carry_i, zero_i};

    // Stage register: flush empties the slot, otherwise it loads whenever it may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sh_q    <= SH_LSL;
            shamt_q <= {LW{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (advance_s) begin
            valid_q <= valid_i;
            if (valid_i) begin
                sh_q    <= sh_i;
                shamt_q <= shamt_i;
                data_q  <= data_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign sh_o    = sh_q;
    assign shamt_o = shamt_q;
    assign data_o  = data_q;
    assign carry_o = carry_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/shift_pipe.sv
// Parametrised pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry and zero
// flags, valid/ready handshake, backpressure and flush.
module shift_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      Flush,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [1:0]                Sh,
    input  logic [clog2_w(WIDTH)-1:0] Shamt,
    input  logic [WIDTH-1:0]          ShIn,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [WIDTH-1:0]          ShOut,
    output logic                      Carry,
    output logic                      Zero
);

    localparam int LW = clog2_w(WIDTH);

    // Index k is the input of stage k; index STAGES is the pipe output.
    logic             valid_s [0:STAGES];
    logic             ready_s [0:STAGES];
    sh_e              sh_s    [0:STAGES];
    logic [LW-1:0]    shamt_s [0:STAGES];
    logic [WIDTH-1:0] data_s  [0:STAGES];
    logic             carry_s [0:STAGES];
    logic             zero_s  [0:STAGES];
    logic             unused_ok;

    assign valid_s[0]      = InValid;
    assign sh_s[0]         = sh_e'(Sh);
    assign shamt_s[0]      = Shamt;
    assign data_s[0]       = ShIn;
    assign carry_s[0]      = 1'b0;
    assign zero_s[0]       = 1'b0;
    assign ready_s[STAGES] = OutReady;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int FIRST = stage_first_lvl(k, LW, STAGES);
        localparam int NEXT  = stage_first_lvl(k + 1, LW, STAGES);

        shift_stage #(
            .WIDTH     (WIDTH),
            .FIRST_LVL (FIRST),
            .NUM_LVL   (NEXT - FIRST)
        ) u_stage (
            .clk     (CLK),
            .rst_n   (RESETn),
            .flush_i (Flush),
            .valid_i (valid_s[k]),
            .ready_o (ready_s[k]),
            .ready_i (ready_s[k+1]),
            .sh_i    (sh_s[k]),
            .shamt_i (shamt_s[k]),
            .data_i  (data_s[k]),
            .carry_i (carry_s[k]),
            .zero_i  (zero_s[k]),
            .valid_o (valid_s[k+1]),
            .sh_o    (sh_s[k+1]),
            .shamt_o (shamt_s[k+1]),
            .data_o  (data_s[k+1]),
            .carry_o (carry_s[k+1]),
            .zero_o  (zero_s[k+1])
        );
    end

    assign InReady   = ready_s[0];
    assign OutValid  = valid_s[STAGES];
    assign ShOut     = data_s[STAGES];
    assign Carry     = carry_s[STAGES];
    assign Zero      = zero_s[STAGES];
    assign unused_ok = ^{2'(sh_s[STAGES]), shamt_s[STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed scenarios on a 32-bit/2-stage
// instance plus randomized parameter-sweep instances against a reference model.
module tb_shift_pipe;

    typedef struct {
        logic [63:0] res;
        logic        carry;
        logic        zero;
        int          cyc;
    } item_t;

    localparam int SW_W [6] = '{8, 8, 32, 32, 64, 64};
    localparam int SW_S [6] = '{1, 3, 1, 5, 1, 6};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   sw_done  = 0;
    logic sw_rst_n = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the mode definitions, using wide arithmetic.
    function automatic item_t ref_op(input int w, input logic [1:0] sh, input int amt,
                                     input logic [63:0] x_in, input int cyc);
        logic [63:0] mask, x, r;
        item_t it;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = x_in & mask;
        case (sh)
            2'b00:   r = x << amt;
            2'b01:   r = x >> amt;
            2'b10:   r = (x >> amt) | (x[w-1] ? ~(mask >> amt) : 64'd0);
            default: r = (amt == 0) ? x : ((x >> amt) | (x << (w - amt)));
        endcase
        r = r & mask;
        it.res  = r;
        it.zero = (r == 64'd0);
        if (amt == 0)         it.carry = 1'b0;
        else if (sh == 2'b00) it.carry = x[w - amt];
        else if (sh == 2'b11) it.carry = r[w - 1];
        else                  it.carry = x[amt - 1];
        it.cyc = cyc;
        return it;
    endfunction

    // ---------------- main instance: WIDTH=32, STAGES=2 ----------------
    localparam int MS = 2;

    logic        m_rst_n, m_flush, m_iv, m_ir, m_ov, m_ordy, m_c, m_z;
    logic [1:0]  m_sh;
    logic [4:0]  m_amt;
    logic [31:0] m_x, m_y;
    item_t       m_q[$];
    int          m_cyc = 0;

    shift_pipe #(.WIDTH(32), .STAGES(MS)) u_dut (
        .CLK      (clk),
        .RESETn   (m_rst_n),
        .Flush    (m_flush),
        .InValid  (m_iv),
        .InReady  (m_ir),
        .Sh       (m_sh),
        .Shamt    (m_amt),
        .ShIn     (m_x),
        .OutValid (m_ov),
        .OutReady (m_ordy),
        .ShOut    (m_y),
        .Carry    (m_c),
        .Zero     (m_z)
    );

    // One cycle: drive at the falling edge, check against the in-flight queue, then update it.
    task automatic m_step(input logic iv, input logic [1:0] sh, input logic [4:0] amt,
                          input logic [31:0] x, input logic ordy, input logic fl,
                          input logic use_e, input logic [31:0] e_res, input logic e_c,
                          output logic acc);
        item_t it;
        logic  ev, er;
        @(negedge clk);
        m_cyc++;
        m_iv = iv; m_sh = sh; m_amt = amt; m_x = x; m_ordy = ordy; m_flush = fl;
        #1;
        ev = (m_q.size() > 0) && (m_cyc - m_q[0].cyc >= MS);
        er = ordy || (m_q.size() < MS);
        check_val("out_valid", 64'(m_ov), 64'(ev));
        check_val("in_ready", 64'(m_ir), 64'(er));
        if (ev) begin
            check_val("sh_out", 64'(m_y), m_q[0].res);
            check_val("carry", 64'(m_c), 64'(m_q[0].carry));
            check_val("zero", 64'(m_z), 64'(m_q[0].zero));
        end
        if (ev && ordy) void'(m_q.pop_front());
        acc = iv && er && !fl;
        if (fl) begin
            m_q.delete();
        end else if (acc) begin
            if (use_e) begin
                it.res = {32'd0, e_res}; it.carry = e_c; it.zero = (e_res == 32'd0); it.cyc = m_cyc;
            end else begin
                it = ref_op(32, sh, int'(amt), {32'd0, x}, m_cyc);
            end
            m_q.push_back(it);
        end
    endtask

    task automatic m_rand_step(input logic iv, input logic ordy, input logic fl, output logic acc);
        m_step(iv, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
               ordy, fl, 1'b0, 32'd0, 1'b0, acc);
    endtask

    task automatic m_idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) m_step(1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, acc);
    endtask

    initial begin : main
        logic [31:0] t1_res [4];
        logic        acc;
        int          issued;
        int          t;
        t1_res = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h1800_000F};
        m_rst_n = 1'b0; m_flush = 1'b0; m_iv = 1'b0; m_sh = 2'b00; m_amt = 5'd0;
        m_x = 32'd0; m_ordy = 1'b1;
        #1;
        check_val("rst_out_valid", 64'(m_ov), 64'd0);
        check_val("rst_sh_out", 64'(m_y), 64'd0);
        check_val("rst_carry", 64'(m_c), 64'd0);
        check_val("rst_zero", 64'(m_z), 64'd0);
        check_val("rst_in_ready", 64'(m_ir), 64'd1);
        @(negedge clk);
        @(negedge clk);
        m_rst_n = 1'b1;
        sw_rst_n = 1'b1;

        // Mode check, back-to-back.
        for (int i = 0; i < 4; i++)
            m_step(1'b1, 2'(i), 5'd4, 32'h8000_00F1, 1'b1, 1'b0, 1'b1, t1_res[i], 1'b0, acc);
        m_idle(3);

        // Boundaries.
        m_step(1'b1, 2'b11, 5'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, acc);
        m_step(1'b1, 2'b00, 5'd31, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, acc);
        m_step(1'b1, 2'b01, 5'd1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, acc);
        m_idle(3);

        // Backpressure: 8 ops, OutReady low for cycles 3..7.
        issued = 0;
        t = 0;
        while (issued < 8 && t < 40) begin
            m_rand_step(1'b1, !(t >= 3 && t < 8), 1'b0, acc);
            if (acc) issued++;
            t++;
        end
        check_val("bp_issued", 64'(issued), 64'd8);
        m_idle(4);

        // Flush with ops in flight and an offered op on the same edge.
        m_rand_step(1'b1, 1'b1, 1'b0, acc);
        m_rand_step(1'b1, 1'b1, 1'b0, acc);
        m_rand_step(1'b1, 1'b1, 1'b1, acc);
        m_idle(1);
        check_val("flush_out_valid", 64'(m_ov), 64'd0);
        m_step(1'b1, 2'b01, 5'd8, 32'hFF00_0000, 1'b1, 1'b0, 1'b1, 32'h00FF_0000, 1'b0, acc);
        m_idle(3);

        // Asynchronous reset with the pipe full and stalled.
        m_rand_step(1'b1, 1'b0, 1'b0, acc);
        m_rand_step(1'b1, 1'b0, 1'b0, acc);
        m_rand_step(1'b1, 1'b0, 1'b0, acc);
        #2;
        m_rst_n = 1'b0;
        m_iv = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(m_ov), 64'd0);
        check_val("arst_sh_out", 64'(m_y), 64'd0);
        m_q.delete();
        @(negedge clk);
        m_rst_n = 1'b1;
        m_idle(3);

        // Random traffic with backpressure and occasional flush.
        for (int i = 0; i < 200; i++)
            m_rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 31) == 0, acc);
        m_idle(4);
        check_val("main_drained", 64'(m_q.size()), 64'd0);

        wait (sw_done == 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 6; g++) begin : g_sweep
        localparam int W  = SW_W[g];
        localparam int S  = SW_S[g];
        localparam int LW = $clog2(W);

        logic          iv, ir, ov, ordy, c, z;
        logic [1:0]    sh;
        logic [LW-1:0] amt;
        logic [W-1:0]  x, y;

        shift_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .CLK      (clk),
            .RESETn   (sw_rst_n),
            .Flush    (1'b0),
            .InValid  (iv),
            .InReady  (ir),
            .Sh       (sh),
            .Shamt    (amt),
            .ShIn     (x),
            .OutValid (ov),
            .OutReady (ordy),
            .ShOut    (y),
            .Carry    (c),
            .Zero     (z)
        );

        initial begin : run
            item_t q[$];
            int    cyc;
            logic  ev, er;
            iv = 1'b0; ordy = 1'b1; sh = 2'b00; amt = '0; x = '0; cyc = 0;
            wait (sw_rst_n === 1'b1);
            for (int n = 0; n < 320; n++) begin
                @(negedge clk);
                cyc++;
                ordy = (n >= 280) ? 1'b1 : ($urandom_range(0, 3) != 0);
                iv   = (n < 280) && ($urandom_range(0, 2) != 0);
                sh   = 2'($urandom_range(0, 3));
                amt  = LW'($urandom_range(0, W - 1));
                x    = W'({$urandom, $urandom});
                #1;
                ev = (q.size() > 0) && (cyc - q[0].cyc >= S);
                er = ordy || (q.size() < S);
                check_val($sformatf("sw%0d_out_valid", g), 64'(ov), 64'(ev));
                check_val($sformatf("sw%0d_in_ready", g), 64'(ir), 64'(er));
                if (ev) begin
                    check_val($sformatf("sw%0d_sh_out", g), 64'(y), q[0].res);
                    check_val($sformatf("sw%0d_carry", g), 64'(c), 64'(q[0].carry));
                    check_val($sformatf("sw%0d_zero", g), 64'(z), 64'(q[0].zero));
                end
                if (ev && ordy) void'(q.pop_front());
                if (iv && er) q.push_back(ref_op(W, sh, int'(amt), 64'(x), cyc));
            end
            check_val($sformatf("sw%0d_drained", g), 64'(q.size()), 64'd0);
            sw_done++;
        end
    end

endmodule
